// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine for one 128-bit state.
// COLS_PER_CYCLE columns are transformed per clock; the result is published only once the whole block is done.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NBEATS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] BEAT_LAST = 2'(NBEATS - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [3:0][31:0]  data_q, data_d;
  logic              dec_q, dec_d;
  logic [127:0]      out_q, out_d;
  logic              valid_q, valid_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient is a sum of x, 2x, 4x, 8x; row i uses k0..k3 on bytes i..i+3 (mod 4).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic dec);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] k0 [4];
    logic [7:0] k1 [4];
    logic [7:0] k2 [4];
    logic [7:0] k3 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      if (dec) begin
        k0[i] = x8[i] ^ x4[i] ^ x2[i];
        k1[i] = x8[i] ^ x2[i] ^ a[i];
        k2[i] = x8[i] ^ x4[i] ^ a[i];
        k3[i] = x8[i] ^ a[i];
      end else begin
        k0[i] = x2[i];
        k1[i] = x2[i] ^ a[i];
        k2[i] = a[i];
        k3[i] = a[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = k0[i] ^ k1[(i+1)%4] ^ k2[(i+2)%4] ^ k3[(i+3)%4];
    end
    return r;
  endfunction

  logic [1:0]  col_sel [COLS_PER_CYCLE];
  logic [31:0] col_mix [COLS_PER_CYCLE];

  // Column 0 sits in the top word of data_q, hence the 3-c index.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_sel[j] = beat_q * 2'(COLS_PER_CYCLE) + 2'(j);
    assign col_mix[j] = mix_col(data_q[2'd3 - col_sel[j]], dec_q);
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    dec_d   = dec_q;
    out_d   = out_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          dec_d   = in_dec;
          beat_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          data_d[2'd3 - col_sel[j]] = col_mix[j];
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == BEAT_LAST) begin
          out_d   = data_d;
          valid_d = 1'b1;
          beat_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      dec_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      dec_q   <= dec_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = valid_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) share one input stream.
// Expected values are the FIPS-197 MixColumns vectors and hand-computed column results.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_dec;
  logic         out_ready;

  logic         in_ready_1, out_valid_1, busy_1;
  logic [127:0] out_data_1;
  logic         in_ready_2, out_valid_2, busy_2;
  logic [127:0] out_data_2;
  logic         in_ready_4, out_valid_4, busy_4;
  logic [127:0] out_data_4;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FWD_IN   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FWD_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] ONES     = 128'h01010101010101010101010101010101;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_data(in_data), .in_dec(in_dec), .out_valid(out_valid_1),
    .out_ready(out_ready), .out_data(out_data_1), .busy(busy_1)
  );

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_data(in_data), .in_dec(in_dec), .out_valid(out_valid_2),
    .out_ready(out_ready), .out_data(out_data_2), .busy(busy_2)
  );

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_data(in_data), .in_dec(in_dec), .out_valid(out_valid_4),
    .out_ready(out_ready), .out_data(out_data_4), .busy(busy_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one block to all three instances and checks each one's latency and result.
  task automatic applyStimulus(input logic [127:0] d, input logic dec, input logic [127:0] expected, input string tag);
    in_valid = 1'b1;
    in_data  = d;
    in_dec   = dec;
    step();
    in_valid = 1'b0;
    checkOutput({tag, "_busy_c1"}, 128'(busy_1), 128'(1'b1));
    for (int k = 1; k <= 4; k++) begin
      step();
      checkOutput({tag, "_valid_c1"}, 128'(out_valid_1), 128'(k == 4));
      checkOutput({tag, "_valid_c2"}, 128'(out_valid_2), 128'(k == 2));
      checkOutput({tag, "_valid_c4"}, 128'(out_valid_4), 128'(k == 1));
      if (k == 4) checkOutput({tag, "_data_c1"}, out_data_1, expected);
      if (k == 2) checkOutput({tag, "_data_c2"}, out_data_2, expected);
      if (k == 1) checkOutput({tag, "_data_c4"}, out_data_4, expected);
    end
    step();
    checkOutput({tag, "_valid_drop_c1"}, 128'(out_valid_1), 128'(1'b0));
    checkOutput({tag, "_data_hold_c1"}, out_data_1, expected);
    checkOutput({tag, "_ready_back_c1"}, 128'(in_ready_1), 128'(1'b1));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dec    = 1'b0;
    out_ready = 1'b1;

    #12;
    checkOutput("rst_in_ready_c1", 128'(in_ready_1), 128'(1'b1));
    checkOutput("rst_in_ready_c4", 128'(in_ready_4), 128'(1'b1));
    checkOutput("rst_out_valid_c1", 128'(out_valid_1), 128'(1'b0));
    checkOutput("rst_out_data_c1", out_data_1, '0);
    checkOutput("rst_busy_c1", 128'(busy_1), 128'(1'b0));
    rst_n = 1'b1;

    applyStimulus(FWD_IN, 1'b0, FWD_OUT, "fwd");
    applyStimulus(FWD_OUT, 1'b1, FWD_IN, "inv");
    applyStimulus(COL_IN, 1'b0, COL_OUT, "col_fwd");
    applyStimulus(COL_OUT, 1'b1, COL_IN, "col_inv");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = FWD_IN;
    in_dec    = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    checkOutput("bp_valid_c1", 128'(out_valid_1), 128'(1'b1));
    checkOutput("bp_data_c1", out_data_1, FWD_OUT);
    in_valid = 1'b1;
    in_data  = FWD_OUT;
    in_dec   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("bp_hold_valid_c1", 128'(out_valid_1), 128'(1'b1));
      checkOutput("bp_hold_data_c1", out_data_1, FWD_OUT);
      checkOutput("bp_hold_ready_c1", 128'(in_ready_1), 128'(1'b0));
      checkOutput("bp_hold_ready_c4", 128'(in_ready_4), 128'(1'b0));
    end
    out_ready = 1'b1;
    step();
    checkOutput("bp_handshake_valid_c1", 128'(out_valid_1), 128'(1'b0));
    checkOutput("bp_handshake_idle_c1", 128'(in_ready_1), 128'(1'b1));
    step();
    in_valid = 1'b0;
    checkOutput("bp_accept_busy_c1", 128'(busy_1), 128'(1'b1));
    checkOutput("bp_accept_ready_c1", 128'(in_ready_1), 128'(1'b0));
    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput("bp_partial_valid_c1", 128'(out_valid_1), 128'(1'b0));
      checkOutput("bp_partial_data_c1", out_data_1, FWD_OUT);
    end
    step();
    checkOutput("bp_second_valid_c1", 128'(out_valid_1), 128'(1'b1));
    checkOutput("bp_second_data_c1", out_data_1, FWD_IN);
    step();

    $display("[TB] reset mid-operation");
    in_valid = 1'b1;
    in_data  = COL_IN;
    in_dec   = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid_c1", 128'(out_valid_1), 128'(1'b0));
    checkOutput("midrst_data_c1", out_data_1, '0);
    checkOutput("midrst_ready_c1", 128'(in_ready_1), 128'(1'b1));
    checkOutput("midrst_busy_c1", 128'(busy_1), 128'(1'b0));
    #2 rst_n = 1'b1;
    applyStimulus(ONES, 1'b0, ONES, "after_rst");

    $display("[TB] mode latching");
    in_valid = 1'b1;
    in_data  = FWD_OUT;
    in_dec   = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_dec  = ~in_dec;
      in_data = ~in_data;
      step();
      if (k == 1) checkOutput("latch_data_c4", out_data_4, FWD_IN);
      if (k == 2) checkOutput("latch_data_c2", out_data_2, FWD_IN);
    end
    checkOutput("latch_valid_c1", 128'(out_valid_1), 128'(1'b1));
    checkOutput("latch_data_c1", out_data_1, FWD_IN);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential, parametrised AES MixColumns engine for the 128-bit round datapath.
- Supports forward MixColumns (encrypt) and InvMixColumns (decrypt), selected per block.
- Processes COLS_PER_CYCLE columns per clock, so area and throughput can be traded off.
- Sits between ShiftRows/InvShiftRows and AddRoundKey; valid/ready handshake on both sides.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2, 4; any other value is an elaboration error.
- NBEATS, 4/COLS_PER_CYCLE, derived localparam; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_dec are valid.
- in_ready  output  1  engine can accept a block.
- in_data  input  128  state; byte k = in_data[127-8k -: 8]; column c = bytes 4c..4c+3; row 0 first.
- in_dec  input  1  0 = MixColumns, 1 = InvMixColumns.
- out_valid  output  1  out_data holds a finished block.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  transformed state, same byte order as in_data.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: out_valid=0, out_data=0, busy=0, beat counter=0, internal state register=0, mode register=0.
- in_ready = (state==IDLE), so it reads 1 during and after reset.
- IDLE: on an edge with in_valid&in_ready, latch in_data and in_dec, clear the beat counter, go to BUSY. Otherwise stay.
- BUSY, per edge:
  - Transform COLS_PER_CYCLE columns, starting at column beat*COLS_PER_CYCLE, using the latched mode.
  - Write the results into the result register; untouched columns keep their values.
  - Increment the beat counter.
  - On the beat with index NBEATS-1, go to DONE and set out_valid.
- Latency: out_valid rises exactly NBEATS clocks after the accept edge (4, 2 or 1).
- DONE:
  - Hold out_data and out_valid stable until out_ready is sampled high.
  - On that edge, clear out_valid and go to IDLE.
  - The next block can be accepted no earlier than the following edge. No overlap of input acceptance with DONE.
- out_data changes only on the final BUSY beat. Partial column results are never exposed, and out_data is valid only when out_valid=1.
- in_data/in_dec changes after acceptance have no effect on the block in flight.
- in_valid while busy is ignored; the held stimulus is accepted once IDLE returns.
- Arithmetic in GF(2^8), polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- Forward column (a0..a3 -> r0..r3): r0 = 2a0^3a1^a2^a3, r1 = a0^2a1^3a2^a3, r2 = a0^a1^2a2^3a3, r3 = 3a0^a1^a2^2a3.
- Inverse column: row coefficients (0E,0B,0D,09), rotated right by one per row. All products are built from xtime chains; no general multiplier.
- rst_n low at any time, including mid-BUSY or in DONE:
  - Immediately return to IDLE; out_valid=0, out_data=0; the in-flight block is discarded.
  - First accept is possible on the first rising edge with rst_n high.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- Forward, COLS_PER_CYCLE=1: in_data=d4bf5d30e0b452aeb84111f11e2798e5, in_dec=0, out_ready=1 -> out_valid rises 4 clocks after accept with out_data=046681e5e0cb199a48f8d37a2806264c, held for one cycle.
- Inverse, repeated for COLS_PER_CYCLE=1, 2, 4: in_data=046681e5e0cb199a48f8d37a2806264c, in_dec=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5 after 4, 2, 1 clocks respectively.
- Column vectors, forward: in_data=db135345f20a225c01010101c6c6c6c6 -> 8e4da1bc9fdc589d01010101c6c6c6c6. The same run with in_dec=1 on the output returns the input.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data/out_valid stable and in_ready=0 throughout; a new in_valid applied meanwhile is accepted only on the edge after the out_ready handshake.
- Reset mid-operation: assert rst_n low on beat 2 of a COLS_PER_CYCLE=1 block -> out_valid=0 and out_data=0 asynchronously, in_ready=1. Release rst_n, send 01010101...01 forward -> correct output after 4 clocks.
- Mode latching: accept with in_dec=1, then toggle in_dec and in_data every cycle while BUSY -> output is the inverse transform of the originally accepted block.
